// File: rtl/lcu_adder64.sv
// rtl/lcu_adder64.sv - 64-bit lookahead-carry adder (4/16/64-bit LCU tree), registered outputs; optional input stage via LCU_ADDER64_INREG_EN
// Contains the shared 4-way LCU cell, the 4-bit CLA leaf and the top-level adder.

module lcu_adder64_lcu4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       ci,
    output logic [3:0] c,
    output logic       pg,
    output logic       gg
);
    // Every carry is a flat sum of products of the incoming pairs and ci; nothing ripples.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign pg   = &p;
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module lcu_adder64_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       pg,
    output logic       gg
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    lcu_adder64_lcu4 u_lcu (
        .p  (p),
        .g  (g),
        .ci (ci),
        .c  (c),
        .pg (pg),
        .gg (gg)
    );

    assign s = p ^ c;
endmodule

module lcu_adder64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout,
    output logic        pg,
    output logic        gg,
    output logic        out_vld
);
    logic [63:0] a_t;
    logic [63:0] b_t;
    logic        cin_t;
    logic        vld_t;

`ifdef LCU_ADDER64_INREG_EN
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic        cin_q;
    logic        vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            a_q   <= a;
            b_q   <= b;
            cin_q <= cin;
            vld_q <= in_vld;
        end
    end

    assign a_t   = a_q;
    assign b_t   = b_q;
    assign cin_t = cin_q;
    assign vld_t = vld_q;
`else
    assign a_t   = a;
    assign b_t   = b;
    assign cin_t = cin;
    assign vld_t = in_vld;
`endif

    logic [63:0] sum_c;
    logic [15:0] pg4;
    logic [15:0] gg4;
    logic [15:0] c4;
    logic [3:0]  pg16;
    logic [3:0]  gg16;
    logic [3:0]  c16;
    logic        pg_c;
    logic        gg_c;

    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_cla
            lcu_adder64_cla4 u_cla (
                .a  (a_t[4*i +: 4]),
                .b  (b_t[4*i +: 4]),
                .ci (c4[i]),
                .s  (sum_c[4*i +: 4]),
                .pg (pg4[i]),
                .gg (gg4[i])
            );
        end
        for (i = 0; i < 4; i++) begin : g_l2
            lcu_adder64_lcu4 u_l2 (
                .p  (pg4[4*i +: 4]),
                .g  (gg4[4*i +: 4]),
                .ci (c16[i]),
                .c  (c4[4*i +: 4]),
                .pg (pg16[i]),
                .gg (gg16[i])
            );
        end
    endgenerate

    // gg never depends on ci, so it is already the "cin forced to 0" carry out.
    lcu_adder64_lcu4 u_l3 (
        .p  (pg16),
        .g  (gg16),
        .ci (cin_t),
        .c  (c16),
        .pg (pg_c),
        .gg (gg_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= '0;
            cout    <= 1'b0;
            pg      <= 1'b0;
            gg      <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            sum     <= sum_c;
            cout    <= gg_c | (pg_c & cin_t);
            pg      <= pg_c;
            gg      <= gg_c;
            out_vld <= vld_t;
        end
    end
endmodule

// File: tb/tb_lcu_adder64.sv
// tb/tb_lcu_adder64.sv - randomized and directed check of lcu_adder64 against a 65-bit arithmetic reference
module tb_lcu_adder64;
`ifdef LCU_ADDER64_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        cin = 1'b0;
    logic [63:0] sum;
    logic        cout;
    logic        pg;
    logic        gg;
    logic        out_vld;

    int total = 0;
    int bad = 0;

    lcu_adder64 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .sum     (sum),
        .cout    (cout),
        .pg      (pg),
        .gg      (gg),
        .out_vld (out_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          vld;
        logic [63:0] sum;
        bit          cout;
        bit          pg;
        bit          gg;
    } exp_t;

    exp_t pipe[$];

    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic ci, input logic v);
        exp_t e;
        logic [64:0] full;
        logic [64:0] nocin;
        full   = {1'b0, x} + {1'b0, y} + {64'd0, ci};
        nocin  = {1'b0, x} + {1'b0, y};
        e.vld  = v;
        e.sum  = full[63:0];
        e.cout = full[64];
        e.gg   = nocin[64];
        e.pg   = ((x ^ y) == 64'hFFFF_FFFF_FFFF_FFFF);
        return e;
    endfunction

    // Expected output stream: front of the queue is what the outputs must show now.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_t z;
            z = '{vld: 1'b0, sum: 64'd0, cout: 1'b0, pg: 1'b0, gg: 1'b0};
            pipe.delete();
            for (int k = 0; k < LAT; k++) pipe.push_back(z);
        end else begin
            pipe.push_back(model(a, b, cin, in_vld));
            void'(pipe.pop_front());
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && pipe.size() == LAT) begin
            chk("out_vld", {63'd0, out_vld}, {63'd0, pipe[0].vld});
            if (pipe[0].vld) begin
                chk("sum", sum, pipe[0].sum);
                chk("cout", {63'd0, cout}, {63'd0, pipe[0].cout});
                chk("pg", {63'd0, pg}, {63'd0, pipe[0].pg});
                chk("gg", {63'd0, gg}, {63'd0, pipe[0].gg});
            end
        end
    end

    task automatic directed(input string name, input logic [63:0] x, input logic [63:0] y, input logic ci,
                            input logic [63:0] es, input logic ec, input logic ep, input logic eg);
        @(posedge clk);
        #1;
        a = x; b = y; cin = ci; in_vld = 1'b1;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        chk({name, ".vld"}, {63'd0, out_vld}, 64'd1);
        chk({name, ".sum"}, sum, es);
        chk({name, ".cout"}, {63'd0, cout}, {63'd0, ec});
        chk({name, ".pg"}, {63'd0, pg}, {63'd0, ep});
        chk({name, ".gg"}, {63'd0, gg}, {63'd0, eg});
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: v = ONES;
            1: v = 64'd0;
            2: v = 64'd1;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        #1;
        chk("reset.sum", sum, 64'd0);
        chk("reset.vld", {63'd0, out_vld}, 64'd0);
        chk("reset.cout", {63'd0, cout}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        directed("T1a", 64'd0, ONES, 1'b0, ONES, 1'b0, 1'b1, 1'b0);
        directed("T1b", 64'd0, ONES, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0);
        directed("T2a", ONES, ONES, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1);
        directed("T2b", ONES, ONES, 1'b1, ONES, 1'b1, 1'b0, 1'b1);
        directed("T3a", 64'd1, ONES, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        directed("T3b", 64'd1, ONES, 1'b1, 64'd1, 1'b1, 1'b0, 1'b1);
        directed("T4", 64'h1111_1111_1111_1111, 64'hEEEE_EEEE_EEEE_EEEE, 1'b0, ONES, 1'b0, 1'b1, 1'b0);
        directed("T5a", 64'h1000_0000_0000_0000, 64'h0000_1000_0000_0000, 1'b0,
                 64'h1000_1000_0000_0000, 1'b0, 1'b0, 1'b0);
        directed("T5b", 64'h1000, 64'h1, 1'b0, 64'h1001, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-stream with in_vld high.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            a = rnd64(); b = rnd64(); cin = 1'($urandom()); in_vld = 1'b1;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("T6.sum", sum, 64'd0);
        chk("T6.cout", {63'd0, cout}, 64'd0);
        chk("T6.pg", {63'd0, pg}, 64'd0);
        chk("T6.gg", {63'd0, gg}, 64'd0);
        chk("T6.vld", {63'd0, out_vld}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 10000; k++) begin
            @(posedge clk);
            #1;
            a = rnd64(); b = rnd64(); cin = 1'($urandom());
            in_vld = ($urandom_range(0, 9) != 0);
        end
        @(posedge clk);
        #1 in_vld = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
